// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared constants, state encoding and alignment helper for the memory initiator
package mem_if_pkg;

    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;

    localparam logic [31:0] PORT_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Size 3 is not a legal access width, so it is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - sign/zero extension of byte, half and word load data
// Ports:
//   data_i     - raw 32-bit read data from the controller
//   size_i     - access size (byte/half/word)
//   unsigned_i - 1 = zero-extend, 0 = sign-extend
//   result_o   - extended 32-bit load result
module mem_load_ext
    import mem_if_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic byte_sign;
    logic half_sign;

    assign byte_sign = ~unsigned_i & data_i[7];
    assign half_sign = ~unsigned_i & data_i[15];

    // Only the low lanes are looked at for narrow loads; upper read bits are don't-care.
    always_comb begin
        case (size_i)
            SZ_BYTE: result_o = {{24{byte_sign}}, data_i[7:0]};
            SZ_HALF: result_o = {{16{half_sign}}, data_i[15:0]};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - core-side fetch/load-store initiator for the SRAM controller request interface
// Ports:
//   clk, reset                       - clock, synchronous active-low reset
//   if_req/if_addr -> if_done/if_instr
//                                    - instruction fetch request and completion
//   ls_req/ls_we/ls_addr/ls_wdata/ls_size/ls_unsigned -> ls_done/ls_rdata/ls_err
//                                    - load/store request and completion
//   mem_address/mem_rw_req/mem_rw/mem_write_data/mem_size, mem_read_data/mem_data_valid
//                                    - controller request/response
//   timeout_err                      - sticky flag, set on any timeout
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_instr,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_address,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_read_data,
    input  logic        mem_data_valid,
    output logic        timeout_err
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        owner_ls_q, owner_ls_d;
    logic        unsigned_q, unsigned_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        ls_err_q, ls_err_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_rw_req_q, mem_rw_req_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] ext_data;

    // Extension uses the size latched at issue, which the controller also still sees.
    mem_load_ext u_load_ext (
        .data_i     (mem_read_data),
        .size_i     (mem_size_q),
        .unsigned_i (unsigned_q),
        .result_o   (ext_data)
    );

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        owner_ls_d       = owner_ls_q;
        unsigned_d       = unsigned_q;
        if_done_d        = 1'b0;
        if_instr_d       = if_instr_q;
        ls_done_d        = 1'b0;
        ls_rdata_d       = ls_rdata_q;
        ls_err_d         = 1'b0;
        mem_address_d    = mem_address_q;
        mem_rw_req_d     = 1'b0;
        mem_rw_d         = mem_rw_q;
        mem_write_data_d = mem_write_data_q;
        mem_size_d       = mem_size_q;
        timeout_err_d    = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (ls_req) begin
                    owner_ls_d = 1'b1;
                    unsigned_d = ls_unsigned;
                    if (is_misaligned(ls_size, ls_addr[1:0])) begin
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = 32'd0;
                        state_d    = ST_DONE;
                    end else begin
                        mem_address_d    = ls_addr;
                        mem_rw_d         = ls_we;
                        mem_write_data_d = ls_wdata;
                        mem_size_d       = ls_size;
                        mem_rw_req_d     = 1'b1;
                        timer_d          = 8'd0;
                        state_d          = ST_WAIT;
                    end
                end else if (if_req) begin
                    owner_ls_d       = 1'b0;
                    mem_address_d    = if_addr;
                    mem_rw_d         = 1'b0;
                    mem_write_data_d = 32'd0;
                    mem_size_d       = SZ_WORD;
                    mem_rw_req_d     = 1'b1;
                    timer_d          = 8'd0;
                    state_d          = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the last timer cycle still counts as a response.
                if (mem_data_valid) begin
                    if (owner_ls_q) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = mem_rw_q ? 32'd0 : ext_data;
                    end else begin
                        if_done_d  = 1'b1;
                        if_instr_d = mem_read_data;
                    end
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    if (owner_ls_q) begin
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = 32'd0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_instr_d = NOP_INSTR;
                    end
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            // One idle cycle lets the requester drop req and the controller return to idle.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            timer_q          <= 8'd0;
            owner_ls_q       <= 1'b0;
            unsigned_q       <= 1'b0;
            if_done_q        <= 1'b0;
            if_instr_q       <= 32'd0;
            ls_done_q        <= 1'b0;
            ls_rdata_q       <= 32'd0;
            ls_err_q         <= 1'b0;
            mem_address_q    <= 32'd0;
            mem_rw_req_q     <= 1'b0;
            mem_rw_q         <= 1'b0;
            mem_write_data_q <= 32'd0;
            mem_size_q       <= 2'd0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            owner_ls_q       <= owner_ls_d;
            unsigned_q       <= unsigned_d;
            if_done_q        <= if_done_d;
            if_instr_q       <= if_instr_d;
            ls_done_q        <= ls_done_d;
            ls_rdata_q       <= ls_rdata_d;
            ls_err_q         <= ls_err_d;
            mem_address_q    <= mem_address_d;
            mem_rw_req_q     <= mem_rw_req_d;
            mem_rw_q         <= mem_rw_d;
            mem_write_data_q <= mem_write_data_d;
            mem_size_q       <= mem_size_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign if_done        = if_done_q;
    assign if_instr       = if_instr_q;
    assign ls_done        = ls_done_q;
    assign ls_rdata       = ls_rdata_q;
    assign ls_err         = ls_err_q;
    assign mem_address    = mem_address_q;
    assign mem_rw_req     = mem_rw_req_q;
    assign mem_rw         = mem_rw_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_size       = mem_size_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - scoreboard testbench for mem_initiator
module tb_mem_initiator;
    import mem_if_pkg::*;

    localparam int TMO = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_instr;
    logic        ls_req, ls_we, ls_unsigned, ls_done, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_size, mem_size;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_rw_req, mem_rw, mem_data_valid, timeout_err;

    always #5 clk = ~clk;

    mem_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_instr(if_instr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_size(ls_size), .ls_unsigned(ls_unsigned), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_address(mem_address), .mem_rw_req(mem_rw_req), .mem_rw(mem_rw),
        .mem_write_data(mem_write_data), .mem_size(mem_size),
        .mem_read_data(mem_read_data), .mem_data_valid(mem_data_valid),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic        is_ls;
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [1:0]  size;
    } req_t;

    resp_t exp_resp[$];
    req_t  exp_req[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response and request monitor
    logic prev_rw_req = 1'b0;
    always @(negedge clk) begin
        resp_t r;
        req_t  q;
        if (reset) begin
            if (if_done || ls_done) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_done", {30'd0, if_done, ls_done}, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    check("done_side", {30'd0, if_done, ls_done}, {30'd0, ~r.is_ls, r.is_ls});
                    check("done_data", ls_done ? ls_rdata : if_instr, r.data);
                    check("done_err", {31'd0, ls_err}, {31'd0, r.err});
                end
            end
            if (mem_rw_req) begin
                check("rw_req_single_cycle", {31'd0, prev_rw_req}, 32'd0);
                if (exp_req.size() == 0) begin
                    check("unexpected_rw_req", {31'd0, mem_rw_req}, 32'd0);
                end else begin
                    q = exp_req.pop_front();
                    check("req_addr", mem_address, q.addr);
                    check("req_wdata", mem_write_data, q.wdata);
                    check("req_rw_size", {29'd0, mem_rw, mem_size}, {29'd0, q.rw, q.size});
                end
            end
        end
        prev_rw_req = mem_rw_req;
    end

    // Controller model
    int          model_lat     = 1;
    logic        model_respond = 1'b1;
    logic [31:0] model_data    = 32'd0;
    int          reset_edges   = 0;

    always @(posedge clk) if (!reset) reset_edges++;

    initial begin
        logic [31:0] cap_addr, cap_wdata;
        logic [2:0]  cap_rs;
        int          cap_resets;
        mem_data_valid = 1'b0;
        mem_read_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_rw_req && reset && model_respond) begin
                cap_addr   = mem_address;
                cap_wdata  = mem_write_data;
                cap_rs     = {mem_rw, mem_size};
                cap_resets = reset_edges;
                repeat (model_lat - 1) @(negedge clk);
                if (cap_resets == reset_edges) begin
                    check("hold_addr", mem_address, cap_addr);
                    check("hold_wdata", mem_write_data, cap_wdata);
                    check("hold_rw_size", {29'd0, mem_rw, mem_size}, {29'd0, cap_rs});
                end
                mem_read_data  = model_data;
                mem_data_valid = 1'b1;
                @(negedge clk);
                mem_data_valid = 1'b0;
                mem_read_data  = 32'hA5A5_A5A5;
            end
        end
    end

    task automatic ls_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input logic [31:0] exp_data,
                          input logic exp_err, input logic issues, output int cycles);
        logic seen;
        if (issues) exp_req.push_back('{addr, we, wdata, size});
        exp_resp.push_back('{1'b1, exp_data, exp_err});
        ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_size = size; ls_unsigned = uns;
        ls_req = 1'b1;
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cycles++;
            if (ls_done) begin seen = 1'b1; break; end
        end
        check("ls_done_seen", {31'd0, seen}, 32'd1);
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp_data, output int cycles);
        logic seen;
        exp_req.push_back('{addr, 1'b0, 32'd0, SZ_WORD});
        exp_resp.push_back('{1'b0, exp_data, 1'b0});
        if_addr = addr;
        if_req  = 1'b1;
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cycles++;
            if (if_done) begin seen = 1'b1; break; end
        end
        check("if_done_seen", {31'd0, seen}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  cyc;
        logic got_ls, got_if;
        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
        ls_size = 2'd0; ls_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {31'd0, |{if_done, if_instr, ls_done, ls_rdata, ls_err, mem_address,
              mem_rw_req, mem_rw, mem_write_data, mem_size, timeout_err}}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        model_lat = 2; model_data = 32'h0050_0093;
        if_txn(32'h20, 32'h0050_0093, cyc);

        model_data = 32'hDEAD_BE80;
        ls_txn(1'b0, 32'h101, 32'd0, SZ_BYTE, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1, cyc);
        ls_txn(1'b0, 32'h101, 32'd0, SZ_BYTE, 1'b1, 32'h0000_0080, 1'b0, 1'b1, cyc);
        model_data = 32'h1234_8001;
        ls_txn(1'b0, 32'h202, 32'd0, SZ_HALF, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1, cyc);
        ls_txn(1'b0, 32'h202, 32'd0, SZ_HALF, 1'b1, 32'h0000_8001, 1'b0, 1'b1, cyc);
        model_data = 32'hCAFE_F00D;
        ls_txn(1'b0, 32'h204, 32'd0, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, cyc);

        model_lat = 5; model_data = 32'hFFFF_FFFF;
        ls_txn(1'b1, 32'h40, 32'h1234_ABCD, SZ_HALF, 1'b0, 32'd0, 1'b0, 1'b1, cyc);
        model_lat = 1;
        ls_txn(1'b1, PORT_ADDR, 32'h0000_0001, SZ_BYTE, 1'b0, 32'd0, 1'b0, 1'b1, cyc);

        ls_txn(1'b0, 32'h102, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1, 1'b0, cyc);
        check("misaligned_latency", cyc, 32'd1);
        ls_txn(1'b1, 32'h41, 32'h55, SZ_HALF, 1'b0, 32'd0, 1'b1, 1'b0, cyc);
        ls_txn(1'b0, 32'h0, 32'd0, 2'd3, 1'b0, 32'd0, 1'b1, 1'b0, cyc);
        check("no_timeout_yet", {31'd0, timeout_err}, 32'd0);

        // Contention: load first, then fetch
        model_lat = 2; model_data = 32'h1111_2222;
        exp_req.push_back('{32'h80, 1'b0, 32'd0, SZ_WORD});
        exp_req.push_back('{32'h84, 1'b0, 32'd0, SZ_WORD});
        exp_resp.push_back('{1'b1, 32'h1111_2222, 1'b0});
        exp_resp.push_back('{1'b0, 32'h1111_2222, 1'b0});
        ls_we = 1'b0; ls_addr = 32'h80; ls_wdata = 32'd0; ls_size = SZ_WORD; ls_unsigned = 1'b0;
        if_addr = 32'h84;
        ls_req = 1'b1; if_req = 1'b1;
        got_ls = 1'b0; got_if = 1'b0;
        for (int i = 0; i < 100 && !got_if; i++) begin
            @(negedge clk);
            if (ls_done) begin got_ls = 1'b1; ls_req = 1'b0; end
            if (if_done) begin got_if = 1'b1; if_req = 1'b0; end
        end
        check("contention_both_done", {30'd0, got_ls, got_if}, 32'd3);
        ls_req = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Timeouts
        model_respond = 1'b0;
        ls_txn(1'b0, 32'h300, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1, 1'b1, cyc);
        check("ls_timeout_latency", cyc, TMO + 1);
        check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        model_respond = 1'b1;
        ls_txn(1'b0, 32'h304, 32'd0, SZ_WORD, 1'b0, 32'h1111_2222, 1'b0, 1'b1, cyc);
        check("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
        model_respond = 1'b0;
        if_txn(32'h400, NOP_INSTR, cyc);
        check("if_timeout_latency", cyc, TMO + 1);

        // Reset during WAIT, then a stale data_valid
        model_respond = 1'b1; model_lat = 6; model_data = 32'h7777_7777;
        exp_req.push_back('{32'h500, 1'b0, 32'd0, SZ_WORD});
        ls_we = 1'b0; ls_addr = 32'h500; ls_size = SZ_WORD; ls_req = 1'b1;
        got_ls = 1'b0;
        for (int i = 0; i < 20 && !got_ls; i++) begin
            @(negedge clk);
            if (mem_rw_req) got_ls = 1'b1;
        end
        check("reset_test_issued", {31'd0, got_ls}, 32'd1);
        @(negedge clk);
        reset = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        check("reset_in_wait_outputs", {31'd0, |{if_done, if_instr, ls_done, ls_rdata, ls_err, mem_address,
              mem_rw_req, mem_rw, mem_write_data, mem_size, timeout_err}}, 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        check("resp_queue_empty", exp_resp.size(), 32'd0);
        check("req_queue_empty", exp_req.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Core-side initiator for the SRAM memory controller's rw_req/data_valid request interface.
- Arbitrates instruction-fetch and load/store requests from the core and issues one memory transaction at a time.
- Holds all request fields stable until data_valid, then returns sign- or zero-extended load data with a one-cycle done pulse.
- Detects misaligned accesses and unanswered requests (timeout).

Parameters:
TIMEOUT_CYCLES, 64, WAIT cycles without mem_data_valid before abort (2..255)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
if_req  in  1  fetch request, level, held until if_done
if_addr  in  32  fetch address, word-aligned
if_done  out  1  one-cycle fetch completion pulse
if_instr  out  32  fetched word, valid while if_done=1
ls_req  in  1  load/store request, level, held until ls_done
ls_we  in  1  1=store, 0=load
ls_addr  in  32  byte address
ls_wdata  in  32  store data, right-justified
ls_size  in  2  0=byte, 1=half, 2=word
ls_unsigned  in  1  1=zero-extend load, 0=sign-extend
ls_done  out  1  one-cycle completion pulse
ls_rdata  out  32  extended load data, valid while ls_done=1
ls_err  out  1  misaligned/timeout flag, valid with ls_done
mem_address  out  32  to controller address
mem_rw_req  out  1  to controller rw_req
mem_rw  out  1  to controller rw (1=write)
mem_write_data  out  32  to controller write_data
mem_size  out  2  to controller size
mem_read_data  in  32  from controller read_data
mem_data_valid  in  1  from controller data_valid
timeout_err  out  1  sticky, set on any timeout, cleared only by reset

Behaviour:
- Reset (reset=0 at clk edge): state IDLE. All outputs 0, timer 0. Overrides any in-flight transaction; the controller shares the same reset.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE, arbitration: ls_req has priority over if_req. If both are high, only ls is serviced; if_req waits.
- IDLE, ls accepted and misaligned (size 2 with addr[1:0]!=0, size 1 with addr[0]=1, or size 3):
  - No memory access; mem_rw_req stays 0.
  - ls_done=1, ls_err=1, ls_rdata=0; go to DONE.
- IDLE, accepted and aligned:
  - Load mem_address, mem_rw, mem_write_data, mem_size. Fetch uses rw=0, size=2.
  - mem_rw_req=1 for exactly one cycle; timer=0; go to WAIT.
- WAIT:
  - mem_rw_req=0. mem_address/rw/write_data/size held unchanged, because the controller samples rw and write_data after accept.
  - Timer increments each cycle.
  - mem_data_valid=1: capture the response and raise the selected done pulse; go to DONE.
    - fetch: if_instr = mem_read_data.
    - byte load: ls_rdata = ext(mem_read_data[7:0]).
    - half load: ls_rdata = ext(mem_read_data[15:0]).
    - word load: ls_rdata = mem_read_data.
    - store: ls_rdata = 0.
  - Timer reaches TIMEOUT_CYCLES-1 with no data_valid:
    - Abort: done pulse on the owning side.
    - ls side: ls_err=1, ls_rdata=0. Fetch side: if_instr=0x00000013 (NOP).
    - timeout_err set; go to DONE.
  - If data_valid and timeout coincide, data_valid wins.
- DONE: all done/err pulses cleared; go to IDLE. This guarantees the requester has dropped req before IDLE resamples, and gives the controller its idle-return cycle.
- Upper bits of mem_read_data for byte/half loads are don't-care and must never reach ls_rdata.
- Throughput: back-to-back requests take controller latency + 3 cycles each. mem_rw_req is asserted at most once per transaction.
- Address 0xFFFFFF00 (port register) gets no special handling. A store there writes ls_wdata[0] to the port.
- A req dropped mid-transaction is ignored; the transaction still completes and pulses done.

Decomposition:
- Package mem_if_pkg:
  - size constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - state encodings
  - PORT_ADDR=32'hFFFFFF00
  - NOP_INSTR=32'h00000013
- Sub-module mem_load_ext (combinational): data, size, unsigned -> extended 32-bit result.

Test Plan:
- Fetch: if_req, if_addr=0x20, controller model returns 0x00500093 -> exactly one mem_rw_req pulse with size=2, rw=0; if_done 1 cycle with if_instr=0x00500093.
- Signed byte load: ls_addr=0x101, size=0, mem_read_data=0xDEADBE80 -> ls_rdata=0xFFFFFF80. Same with ls_unsigned=1 -> 0x00000080.
- Half store: ls_addr=0x40, ls_wdata=0x1234ABCD, size=1, model asserts data_valid 5 cycles after accept -> mem_write_data=0x1234ABCD, mem_rw=1, fields stable through data_valid; ls_done with ls_err=0.
- Misaligned word: ls_addr=0x102, size=2 -> no mem_rw_req; ls_done=1, ls_err=1 within 1 cycle.
- Contention and timeout:
  - ls_req and if_req rise together -> load serviced first, fetch issued after DONE.
  - Model never responds -> ls_done, ls_err=1 after TIMEOUT_CYCLES; timeout_err stays 1.
- Reset in WAIT -> next cycle all outputs 0, state IDLE; a stale data_valid afterwards produces no done pulse.
